tx_sym_sched: RTL
=================

# tx_sym_sched

Transmit symbol scheduler for the OFDM transmitter. It reads each completed IFFT symbol out of the symbol buffer, prefixes it with a cyclic prefix, and times the valid strobe into the power-fix stage. It tracks samples still in flight through that stage, so frame completion is reported only after the last sample has left it. The block sits between the IFFT output buffer and the power-fix/DAC path.

## Interface
- N_FFT, 512, samples per OFDM symbol (power of two)
- CP_LEN, 128, cyclic-prefix length; 1 ≤ CP_LEN < N_FFT
- ADDR_W, 9, buffer address width, log2(N_FFT)
- PFU_LAT, 4, power-fix stage latency in cycles (di_vld to do_vld)

- clk  in  1  working clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begins a frame
- num_sym  in  8  symbols per frame, sampled when start is accepted
- sym_rdy  in  1  level; the buffer holds a complete symbol
- sym_ack  out  1  one-cycle pulse; current symbol fully read, buffer released
- rd_en  out  1  buffer read enable; read data is valid one cycle later
- rd_addr  out  ADDR_W  buffer read address
- pfu_di_vld  out  1  valid strobe to the power-fix stage (rd_en delayed 1 cycle)
- pfu_do_vld  in  1  valid strobe returned by the power-fix stage
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; last sample of the frame has left the power-fix stage
- sym_cnt  out  8  symbols fully read in the current frame
- underrun  out  1  sticky; sym_rdy was low when the next symbol was due

## Operation
- States: IDLE, WAIT_SYM, CP, BODY, ACK, DRAIN.
- IDLE: start && num_sym≠0 → WAIT_SYM. On this transition: latch num_sym, clear sym_cnt, clear underrun, set busy.
  - start with num_sym=0 is ignored.
  - start in any state other than IDLE is ignored.
- WAIT_SYM: sym_rdy → CP, with rd_addr loaded to N_FFT−CP_LEN.
  - If sym_rdy is low, sym_cnt>0 and the previous state was ACK: set underrun. Then stay in WAIT_SYM.
- CP: rd_en=1, rd_addr increments each cycle. After reading address N_FFT−1 → BODY, with rd_addr loaded to 0.
- BODY: rd_en=1, reads addresses 0..N_FFT−1. After reading N_FFT−1 → ACK.
- ACK: sym_ack=1, sym_cnt increments. Then:
  - if the new sym_cnt = latched num_sym → DRAIN;
  - otherwise → WAIT_SYM.
  - The producer updates sym_rdy on the sym_ack edge, so sym_rdy in WAIT_SYM reflects the next symbol.
- DRAIN: wait until the in-flight counter is 0 → pulse done for one cycle, clear busy → IDLE.
- In-flight counter (width ≥ clog2(PFU_LAT+2)):
  - +1 on pfu_di_vld, −1 on pfu_do_vld, unchanged when both occur in the same cycle.
  - Saturates at 0; a pfu_do_vld with counter at 0 is ignored.
- rd_en is 0 in all states except CP and BODY.
- rd_addr holds its last value when rd_en=0.
- Reset mid-operation: all state, counters and outputs return to reset values next cycle. No sym_ack or done is emitted. The buffer keeps its symbol.

## Timing
- Reset values: rd_en=0, rd_addr=0, pfu_di_vld=0, sym_ack=0, busy=0, done=0, sym_cnt=0, underrun=0, state IDLE, in-flight=0.
- With start accepted at cycle t and sym_rdy high:
  - WAIT_SYM at t+1;
  - first CP read at t+2 (rd_addr=N_FFT−CP_LEN);
  - first pfu_di_vld at t+3.
- Per symbol: CP_LEN+N_FFT read cycles, then a 2-cycle gap (ACK, WAIT_SYM) when the next symbol is already ready. Symbol period is CP_LEN+N_FFT+2 cycles.
- sym_ack is asserted in the cycle after the last BODY read.
- done: last pfu_di_vld at cycle u gives the last pfu_do_vld at u+PFU_LAT. done is asserted at u+PFU_LAT+1.
- busy falls in the same cycle done is pulsed.
- sym_cnt updates in the cycle after sym_ack.

## Test plan
- Single symbol: num_sym=1, sym_rdy=1, start at t.
  - Reads 384..511 then 0..511.
  - 640 pfu_di_vld cycles starting t+3.
  - sym_ack at t+642; done at t+647 (PFU_LAT=4); sym_cnt=1; underrun=0.
- Back-to-back frame: num_sym=3, sym_rdy held high.
  - Exactly 3 sym_ack pulses, 642 cycles apart.
  - 1920 pfu_di_vld cycles in total, one done, underrun=0.
- Underrun: num_sym=2; sym_rdy dropped at the first sym_ack, reasserted 20 cycles later.
  - underrun=1, stays set.
  - Second CP starts 1 cycle after sym_rdy rises.
  - The next start clears underrun.
- Ignored starts: start with num_sym=0 → busy stays 0. Start pulsed during BODY → no effect on addresses or sym_cnt.
- Reset mid-CP: rst at the 10th CP read.
  - Next cycle: all outputs at reset values; no sym_ack, no done.
  - A new start then produces a full, correct frame.
- Drain accounting: pfu_do_vld model delayed PFU_LAT=4 and PFU_LAT=7 (parameter override). done appears exactly PFU_LAT+1 cycles after the last pfu_di_vld.

Source files
------------

// File: rtl/tx_sym_sched.sv
// Transmit symbol scheduler: reads each IFFT symbol out of the symbol buffer
// with its cyclic prefix in front, strobes the samples into the power-fix
// stage, and holds off frame completion until every sample has come back
// out of that stage.
module tx_sym_sched #(
  parameter int N_FFT   = 512,
  parameter int CP_LEN  = 128,
  parameter int ADDR_W  = 9,
  parameter int PFU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        num_sym,
  input  logic              sym_rdy,
  output logic              sym_ack,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pfu_di_vld,
  input  logic              pfu_do_vld,
  output logic              busy,
  output logic              done,
  output logic [7:0]        sym_cnt,
  output logic              underrun
);

  // One spare bit over the strict minimum so a stage that briefly returns
  // more than PFU_LAT+1 samples in flight cannot wrap the counter.
  localparam int FL_W = $clog2(PFU_LAT + 2) + 1;

  localparam logic [ADDR_W-1:0] CP_START  = ADDR_W'(N_FFT - CP_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FFT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYM,
    CP,
    BODY,
    ACK,
    DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        num_lat;
  logic [FL_W-1:0]   inflight;
  logic              prev_ack;
  logic              accept;
  logic              last_rd;
  logic              load_cp;

  assign accept  = (state == IDLE) && start && (num_sym != 8'd0);
  assign last_rd = (rd_addr == LAST_ADDR);
  assign load_cp = (state == WAIT_SYM) && sym_rdy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore/Mealy outputs; busy drops in the done cycle itself.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    sym_ack   = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT_SYM;
      end
      WAIT_SYM: begin
        if (sym_rdy) state_nxt = CP;
      end
      CP: begin
        rd_en = 1'b1;
        if (last_rd) state_nxt = BODY;
      end
      BODY: begin
        rd_en = 1'b1;
        if (last_rd) state_nxt = ACK;
      end
      ACK: begin
        sym_ack = 1'b1;
        if (sym_cnt + 8'd1 == num_lat) state_nxt = DRAIN;
        else                           state_nxt = WAIT_SYM;
      end
      DRAIN: begin
        if (inflight == '0) begin
          done      = 1'b1;
          busy      = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read address: CP starts at N_FFT-CP_LEN and wraps to 0 for the body;
  // after the last body read it parks on N_FFT-1 until the next symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
    end else if (load_cp) begin
      rd_addr <= CP_START;
    end else if (state == CP) begin
      rd_addr <= last_rd ? '0 : rd_addr + ADDR_W'(1);
    end else if (state == BODY && !last_rd) begin
      rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

  // Read data lands one cycle after rd_en, so the strobe follows it by one.
  always_ff @(posedge clk) begin
    if (rst) pfu_di_vld <= 1'b0;
    else     pfu_di_vld <= rd_en;
  end

  // Frame bookkeeping: symbol count, latched length and sticky underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_lat  <= '0;
      sym_cnt  <= '0;
      underrun <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      prev_ack <= (state == ACK);
      if (accept) begin
        num_lat  <= num_sym;
        sym_cnt  <= '0;
        underrun <= 1'b0;
      end else begin
        if (state == ACK) sym_cnt <= sym_cnt + 8'd1;
        // Only the first WAIT_SYM cycle after an ack counts as "next symbol
        // due"; waiting for the very first symbol of a frame is not a fault.
        if (state == WAIT_SYM && !sym_rdy && sym_cnt != 8'd0 && prev_ack)
          underrun <= 1'b1;
      end
    end
  end

  // Samples inside the power-fix stage; a stray return at zero is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({pfu_di_vld, pfu_do_vld})
        2'b10:   inflight <= inflight + FL_W'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - FL_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
